// File: rtl/updown_counter_gen2_pkg.sv
// rtl/updown_counter_gen2_pkg.sv - shared constants and helpers for the up/down counter user module
package updown_counter_gen2_pkg;

   localparam int COUNT_W = 4;

   // Segment patterns {g,f,e,d,c,b,a} for hex digits; index 15 is the leftmost entry
   localparam logic [15:0][6:0] SEG_LUT = {
      7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
      7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
   };

   // A load value above the top of the count sequence saturates at modulus-1
   function automatic logic [COUNT_W-1:0] clamp_load(input logic [2:0] value, input int modulus);
      if (int'(value) > modulus - 1) begin
         return COUNT_W'(modulus - 1);
      end
      return COUNT_W'(value);
   endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// rtl/seg7_hex_decoder.sv - combinational 4-bit to 7-segment decoder
module seg7_hex_decoder
   import updown_counter_gen2_pkg::*;
(
   input  logic [3:0] value,
   output logic [6:0] seg
);

   // Pure table lookup; the display follows the count register with no added latency
   assign seg = SEG_LUT[value];

endmodule

// File: rtl/user_module_updown_counter_gen2.sv
// rtl/user_module_updown_counter_gen2.sv - prescaled up/down mod-N counter with load, wrap flag and 7-seg output (option: UPDOWN_COUNTER_GEN2_DEBOUNCE_EN)
module user_module_updown_counter_gen2
   import updown_counter_gen2_pkg::*;
#(
   parameter int PRESCALE        = 10,
   parameter int MODULUS         = 10,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic [7:0] io_in,
   output logic [7:0] io_out
);

   localparam int                 PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0]      PRESC_MAX  = PW'(PRESCALE - 1);
   localparam logic [COUNT_W-1:0] MAX_COUNT  = COUNT_W'(MODULUS - 1);

   // Reject illegal configurations at elaboration time
   if (PRESCALE < 1 || PRESCALE > 1024) begin : g_bad_prescale
      $error("PRESCALE must be within 1..1024");
   end
   if (MODULUS < 2 || MODULUS > 16) begin : g_bad_modulus
      $error("MODULUS must be within 2..16");
   end
   if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
      $error("DEBOUNCE_CYCLES must be at least 1");
   end

   logic       clk;
   logic       rst_n;
   logic       en;
   logic       up_dn;
   logic       load_raw;
   logic [2:0] load_val;
   logic       load_level;

   assign clk      = io_in[0];
   assign rst_n    = io_in[1];
   assign en       = io_in[2];
   assign up_dn    = io_in[3];
   assign load_raw = io_in[4];
   assign load_val = io_in[7:5];

`ifdef UPDOWN_COUNTER_GEN2_DEBOUNCE_EN
   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

   logic          sync1_q, sync1_d;
   logic          sync2_q, sync2_d;
   logic          filt_q, filt_d;
   logic [DW-1:0] filt_cnt_q, filt_cnt_d;

   // Synchronise the strobe, then flip the filtered level once the new level has held long enough
   always_comb begin
      sync1_d    = load_raw;
      sync2_d    = sync1_q;
      filt_d     = filt_q;
      filt_cnt_d = '0;
      if (sync2_q != filt_q) begin
         if (filt_cnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
            filt_d = sync2_q;
         end else begin
            filt_cnt_d = filt_cnt_q + DW'(1);
         end
      end
   end

   // Debounce state registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_q    <= 1'b0;
         sync2_q    <= 1'b0;
         filt_q     <= 1'b0;
         filt_cnt_q <= '0;
      end else begin
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         filt_q     <= filt_d;
         filt_cnt_q <= filt_cnt_d;
      end
   end

   // Using the next filtered level lets the load land in the same edge the filter settles
   assign load_level = filt_d;
`else
   assign load_level = load_raw;
`endif

   logic [PW-1:0]      presc_q, presc_d;
   logic [COUNT_W-1:0] count_q, count_d;
   logic               wrap_q, wrap_d;
   logic               load_prev_q, load_prev_d;
   logic               step;
   logic               load_edge;
   logic [6:0]         seg;

   // Next count/prescaler/wrap; a load edge wins over a coincident step
   always_comb begin
      presc_d     = presc_q;
      count_d     = count_q;
      wrap_d      = 1'b0;
      load_prev_d = load_level;
      step        = en && (presc_q == PRESC_MAX);
      load_edge   = load_level && !load_prev_q;
      if (load_edge) begin
         count_d = clamp_load(load_val, MODULUS);
         presc_d = '0;
      end else if (en) begin
         if (step) begin
            presc_d = '0;
            if (up_dn) begin
               if (count_q == MAX_COUNT) begin
                  count_d = '0;
                  wrap_d  = 1'b1;
               end else begin
                  count_d = count_q + COUNT_W'(1);
               end
            end else begin
               if (count_q == '0) begin
                  count_d = MAX_COUNT;
                  wrap_d  = 1'b1;
               end else begin
                  count_d = count_q - COUNT_W'(1);
               end
            end
         end else begin
            presc_d = presc_q + PW'(1);
         end
      end
   end

   // Counter state registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         presc_q     <= '0;
         count_q     <= '0;
         wrap_q      <= 1'b0;
         load_prev_q <= 1'b0;
      end else begin
         presc_q     <= presc_d;
         count_q     <= count_d;
         wrap_q      <= wrap_d;
         load_prev_q <= load_prev_d;
      end
   end

   seg7_hex_decoder u_dec (
      .value (count_q),
      .seg   (seg)
   );

   assign io_out = {wrap_q, seg};

endmodule
